// File: rtl/selector_modo.sv
// selector_modo: debounced MODE button driving a 3-state clock-mode FSM (option: MODO_AUTORETORNO_EN)
module selector_modo #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 500000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_modo,
  input  logic       bloqueo,
  output logic [1:0] modo,
  output logic       modo_cambio,
  output logic       btn_estable
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {MODO_HORA = 2'd0, MODO_AJ_HORA = 2'd1, MODO_AJ_MIN = 2'd2} modo_t;
  if (DEBOUNCE_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("selector_modo: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be at least 2");
  end
  logic          s1, btn_sync, estable_q, accept, expira;
  logic [DW-1:0] cnt;
  modo_t         state, sig, nxt;
  // two-flop synchroniser, the only sampler of the raw button
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {btn_sync, s1} <= 2'b00;
    else {btn_sync, s1} <= {s1, btn_modo};
  // accept a new level only after it has persisted DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt         <= '0;
      btn_estable <= 1'b0;
    end else if (btn_sync == btn_estable) cnt <= '0;
    else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      cnt         <= '0;
      btn_estable <= btn_sync;
    end else cnt <= cnt + 1'b1;
  assign accept = btn_estable & ~estable_q & ~bloqueo;
`ifdef MODO_AUTORETORNO_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  assign expira = (state != MODO_HORA) && !bloqueo && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  // inactivity counter: idle in mode 0, frozen while blocked, reset by presses and expiry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tcnt <= '0;
    else if (accept || state == MODO_HORA || expira) tcnt <= '0;
    else if (!bloqueo) tcnt <= tcnt + 1'b1;
`else
  assign expira = 1'b0;
`endif
  // mode register, rising-edge detector and change strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= MODO_HORA;
      estable_q   <= 1'b0;
      modo_cambio <= 1'b0;
    end else begin
      state       <= nxt;
      estable_q   <= btn_estable;
      modo_cambio <= nxt != state;
    end
  // next mode: a press wins over timeout expiry; unknown encodings fall back to 0
  always_comb begin
    sig = MODO_HORA;
    case (state)
      MODO_HORA:    sig = MODO_AJ_HORA;
      MODO_AJ_HORA: sig = MODO_AJ_MIN;
      default:      sig = MODO_HORA;
    endcase
    nxt = accept ? sig : expira ? MODO_HORA : state;
  end
  assign modo = state;
endmodule

// File: tb/tb_selector_modo.sv
// tb_selector_modo: directed scoreboard bench for selector_modo
module tb_selector_modo;
  logic       clk = 1'b0, rst_n = 1'b0, btn_modo = 1'b0, bloqueo = 1'b0;
  logic [1:0] modo;
  logic       modo_cambio, btn_estable;
  int         errors = 0, checks = 0, strobes = 0, dbl = 0, orphan = 0, s0;
  logic [1:0] q[$];
  logic [1:0] prev_modo = 2'd0;
  logic       prev_c = 1'b0;

  selector_modo #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst_n(rst_n), .btn_modo(btn_modo), .bloqueo(bloqueo),
    .modo(modo), .modo_cambio(modo_cambio), .btn_estable(btn_estable)
  );

  always #5 clk = ~clk;

  // strobe bookkeeping: count pulses, catch back-to-back pulses and silent mode changes
  always @(negedge clk) begin
    if (rst_n) begin
      if (modo_cambio) strobes++;
      if (modo_cambio && prev_c) dbl++;
      if (modo != prev_modo && !modo_cambio) orphan++;
    end
    prev_modo = modo;
    prev_c    = modo_cambio;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_change(input string tag);
    int n = 0;
    logic [1:0] e;
    while (modo_cambio !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, int'(n < 40), 1);
    e = (q.size() != 0) ? q.pop_front() : 2'd3;
    check(tag, int'(modo), int'(e));
  endtask

  task automatic press(input logic [1:0] exp, input string tag);
    q.push_back(exp);
    btn_modo = 1'b1;
    wait_change(tag);
    repeat (2) @(negedge clk);
    btn_modo = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_modo", int'(modo), 0);
    check("rst_cambio", int'(modo_cambio), 0);
    check("rst_estable", int'(btn_estable), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_modo", int'(modo), 0);
    // clean press, edge-exact latency
    btn_modo = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 5) check("clean_estable_e5", int'(btn_estable), 0);
      if (k == 6) begin
        check("clean_estable_e6", int'(btn_estable), 1);
        check("clean_modo_e6", int'(modo), 0);
      end
      if (k == 7) begin
        check("clean_modo_e7", int'(modo), 1);
        check("clean_cambio_e7", int'(modo_cambio), 1);
      end
      if (k == 8) check("clean_cambio_e8", int'(modo_cambio), 0);
    end
    btn_modo = 1'b0;
    repeat (6) @(negedge clk);
    check("clean_release_modo", int'(modo), 1);
    check("clean_strobes", strobes, 1);
    // reach mode 2, then async reset between edges while the strobe is high
    q.push_back(2'd2);
    btn_modo = 1'b1;
    wait_change("to_modo2");
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_modo", int'(modo), 0);
    check("async_rst_cambio", int'(modo_cambio), 0);
    check("async_rst_estable", int'(btn_estable), 0);
    btn_modo = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rel_rst_modo", int'(modo), 0);
    check("rel_rst_estable", int'(btn_estable), 0);
    // bounce shorter than the debounce window
    s0 = strobes;
    btn_modo = 1'b1; repeat (3) @(negedge clk);
    btn_modo = 1'b0; repeat (1) @(negedge clk);
    btn_modo = 1'b1; repeat (2) @(negedge clk);
    btn_modo = 1'b0; repeat (12) @(negedge clk);
    check("bounce_estable", int'(btn_estable), 0);
    check("bounce_modo", int'(modo), 0);
    check("bounce_strobes", strobes - s0, 0);
    q.push_back(2'd1);
    btn_modo = 1'b1;
    repeat (6) @(negedge clk);
    btn_modo = 1'b0;
    wait_change("pulse6");
    repeat (8) @(negedge clk);
    // wrap-around 1, 2, 0
    pulse_rst();
    s0 = strobes;
    press(2'd1, "wrap1");
    press(2'd2, "wrap2");
    press(2'd0, "wrap0");
    check("wrap_strobes", strobes - s0, 3);
    // bloqueo discards the press without deferring it
    press(2'd1, "blk_pre");
    s0 = strobes;
    bloqueo = 1'b1;
    btn_modo = 1'b1; repeat (8) @(negedge clk);
    btn_modo = 1'b0; repeat (8) @(negedge clk);
    check("blk_modo", int'(modo), 1);
    check("blk_strobes", strobes - s0, 0);
    bloqueo = 1'b0;
    repeat (3) @(negedge clk);
    check("blk_not_deferred", int'(modo), 1);
    press(2'd2, "blk_post");
`ifdef MODO_AUTORETORNO_EN
    pulse_rst();
    press(2'd1, "to_a1");
    q.push_back(2'd2);
    btn_modo = 1'b1;
    wait_change("to_a2");
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 2) btn_modo = 1'b0;
      if (n == 19) check("tmo_before", int'(modo), 2);
      if (n == 20) begin
        check("tmo_modo", int'(modo), 0);
        check("tmo_cambio", int'(modo_cambio), 1);
      end
    end
    press(2'd1, "to_b1");
    press(2'd2, "to_b2");
    s0 = strobes;
    bloqueo = 1'b1;
    repeat (30) @(negedge clk);
    check("tmo_blk_modo", int'(modo), 2);
    check("tmo_blk_strobes", strobes - s0, 0);
    bloqueo = 1'b0;
`else
    s0 = strobes;
    repeat (40) @(negedge clk);
    check("no_tmo_modo", int'(modo), 2);
    check("no_tmo_strobes", strobes - s0, 0);
`endif
    check("no_double_strobe", dbl, 0);
    check("no_silent_change", orphan, 0);
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
